// File: rtl/npc_pipe_pkg.sv
// Shared sizing helpers and perf-event encoding for the pipeline stage buffers.
package npc_pipe_pkg;

  // Pointer width; a single-entry buffer still needs a 1-bit pointer.
  function automatic int ptr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Occupancy width; must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic stall;
    logic bubble;
  } perf_en_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] value
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready buffer between pipeline stages with flush, occupancy
// and saturating stall/bubble performance counters.
module pipe_stage_buf
  import npc_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [WIDTH-1:0]          s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [WIDTH-1:0]          m_data,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          bubble_cnt
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  if (DEPTH < 1) begin : g_bad_depth
    $error("pipe_stage_buf: DEPTH must be >= 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("pipe_stage_buf: WIDTH must be >= 1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [CW-1:0]    countNext;
  logic             push;
  logic             pop;
  perf_en_t         perfEn;

  // Explicit wrap keeps non-power-of-2 depths legal.
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Ready looks only at registered occupancy, never at m_ready.
  assign s_ready = (count < CW'(DEPTH)) & ~flush & rst;
  assign m_valid = (count != '0) & ~flush;
  assign m_data  = mem[rdPtr];

  assign push = s_valid & s_ready;
  assign pop  = m_valid & m_ready;

  always_comb begin
    countNext = count;
    if (push && !pop) begin
      countNext = count + 1'b1;
    end else if (pop && !push) begin
      countNext = count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wrPtr <= nextPtr(wrPtr);
      end
      if (pop) begin
        rdPtr <= nextPtr(rdPtr);
      end
      count <= countNext;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wrPtr] <= s_data;
    end
  end

  always_comb begin
    perfEn        = '0;
    perfEn.stall  = m_valid & ~m_ready;
    perfEn.bubble = ~m_valid & ~flush;
  end

  sat_counter #(.W(CNT_W)) u_stallCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (perfEn.stall),
    .value (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubbleCnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (perfEn.bubble),
    .value (bubble_cnt)
  );

  assert property (@(posedge clk) disable iff (!rst) count <= CW'(DEPTH))
    else $error("pipe_stage_buf: occupancy exceeds DEPTH");

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Randomized bench: four buffer configurations checked every cycle against
// a queue-based reference of the stage-buffer rules.
module tb_pipe_stage_buf;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sValid;
  logic [3:0] mReady;
  logic [3:0] flush;
  logic [3:0] acceptedW;
  logic [7:0] sData [4];

  int nChecks = 0;
  int nFails  = 0;

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input int k, input logic [31:0] obs,
                          input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s inst%0d @%0t: got %0h want %0h", tag, k, $time, obs, exp);
    end
  endtask

  for (genvar k = 0; k < 4; k++) begin : g
    localparam int D    = (k == 0) ? 2 : (k == 1) ? 3 : (k == 2) ? 4 : 1;
    localparam int CW   = (k == 3) ? 2 : 16;
    localparam int MAXC = (1 << CW) - 1;

    logic [$clog2(D+1)-1:0] cnt;
    logic [CW-1:0]          stall;
    logic [CW-1:0]          bubble;
    logic                   sRdy;
    logic                   mVld;
    logic [7:0]             mDat;
    logic                   acc;

    pipe_stage_buf #(.WIDTH(8), .DEPTH(D), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush[k]),
      .s_valid    (sValid[k]),
      .s_ready    (sRdy),
      .s_data     (sData[k]),
      .m_valid    (mVld),
      .m_ready    (mReady[k]),
      .m_data     (mDat),
      .count      (cnt),
      .stall_cnt  (stall),
      .bubble_cnt (bubble)
    );

    assign acceptedW[k] = acc;

    logic [7:0] q [$];
    int         stallM;
    int         bubbleM;

    initial begin
      acc     = 1'b0;
      stallM  = 0;
      bubbleM = 0;
    end

    // Reference: a bounded FIFO of DEPTH entries plus two saturating tallies.
    always @(negedge clk) begin : model
      bit expMV;
      bit expSR;
      if (!rst) begin
        q.delete();
        stallM  = 0;
        bubbleM = 0;
      end
      expMV = (q.size() != 0) && !flush[k];
      expSR = (q.size() < D) && !flush[k] && (rst == 1'b1);
      checkVal("m_valid", k, 32'(mVld), 32'(expMV));
      checkVal("s_ready", k, 32'(sRdy), 32'(expSR));
      checkVal("count", k, 32'(cnt), 32'(q.size()));
      if (expMV) checkVal("m_data", k, 32'(mDat), 32'(q[0]));
      checkVal("stall_cnt", k, 32'(stall), 32'(stallM));
      checkVal("bubble_cnt", k, 32'(bubble), 32'(bubbleM));
      acc = sValid[k] && expSR;
      if (rst) begin
        if (expMV && !mReady[k] && stallM < MAXC) stallM++;
        if (!expMV && !flush[k] && bubbleM < MAXC) bubbleM++;
        if (flush[k]) begin
          q.delete();
        end else begin
          if (expMV && mReady[k]) void'(q.pop_front());
          if (sValid[k] && expSR) q.push_back(sData[k]);
        end
      end
    end
  end

  // One cycle of stimulus; percentages per input. A pending offer is held
  // until accepted, as the upstream protocol requires.
  task automatic drive(input int pValid, input int pReady, input int pFlush);
    for (int k = 0; k < 4; k++) begin
      if (!(sValid[k] && !acceptedW[k] && !flush[k])) begin
        sValid[k] = ($urandom_range(99) < pValid);
        sData[k]  = 8'($urandom);
      end
      mReady[k] = ($urandom_range(99) < pReady);
      flush[k]  = ($urandom_range(99) < pFlush);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    void'($urandom(32'h5EED));
    rst    = 1'b0;
    sValid = '0;
    mReady = '0;
    flush  = '0;
    for (int k = 0; k < 4; k++) sData[k] = '0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    repeat (5)  drive(0, 0, 0);
    checkVal("bubble_idle", 0, 32'(g[0].bubble), 32'd5);
    repeat (20) drive(100, 100, 0);
    repeat (8)  drive(100, 0, 0);
    checkVal("stall_sat", 3, 32'(g[3].stall), 32'd3);
    repeat (10) drive(0, 100, 0);
    repeat (5)  drive(100, 0, 0);
    drive(100, 0, 100);
    repeat (6)  drive(100, 100, 0);
    repeat (400) drive(70, 60, 5);
    repeat (300) drive(90, 30, 1);
    repeat (12) drive(0, 100, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    nFails++;
    $display("FAIL timeout: got running want finished");
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor to the fixed per-stage bus registers between F/D/X/M/W.
- Carries one opaque packed payload of WIDTH bits under a valid/ready handshake.
- Provides DEPTH-entry elastic buffering, a synchronous flush for branch/trap redirect, an occupancy output and saturating stall/bubble performance counters.
- Sits between any two pipeline stages; the upstream stage drives s_*, the downstream stage drives m_ready.

Parameters:
- WIDTH, 32, payload width in bits (>=1).
- DEPTH, 2, number of buffer entries (>=1). 1 = half-throughput register; >=2 = full throughput.
- CNT_W, 32, width of each performance counter (>=1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset: asynchronous, active-low (asserted when 0).
- flush  input  1  synchronous discard of all buffered entries.
- s_valid  input  1  upstream payload valid.
- s_ready  output  1  buffer can accept a payload.
- s_data  input  WIDTH  upstream payload.
- m_valid  output  1  head entry valid.
- m_ready  input  1  downstream accepts the head entry.
- m_data  output  WIDTH  head entry payload.
- count  output  $clog2(DEPTH+1)  current occupancy.
- stall_cnt  output  CNT_W  cycles with m_valid=1 and m_ready=0.
- bubble_cnt  output  CNT_W  cycles with m_valid=0, flush=0 and rst deasserted.

Behaviour:
- Storage: circular buffer mem[DEPTH], pointers wr_ptr and rd_ptr, plus a count register. Pointers wrap explicitly from DEPTH-1 to 0, so a non-power-of-2 DEPTH is legal. Memory is not reset.
- Reset (rst=0, asynchronous):
  - wr_ptr, rd_ptr, count, stall_cnt and bubble_cnt clear to 0.
  - m_valid=0; s_ready=0 while rst=0.
  - m_data is don't-care while m_valid=0 and is never checked then.
- Output derivation:
  - m_valid = (count!=0) & ~flush.
  - s_ready = (count<DEPTH) & ~flush & rst.
  - m_data = mem[rd_ptr].
  - s_ready depends only on registered state and flush, never combinationally on m_ready. This breaks the ready chain; the cost is that DEPTH=1 sustains at most one transfer every 2 cycles.
- Handshake events:
  - push = s_valid & s_ready; pop = m_valid & m_ready.
  - On push: mem[wr_ptr] <= s_data and wr_ptr advances.
  - On pop: rd_ptr advances.
  - count <= count + push - pop. A simultaneous push and pop leaves count unchanged.
- Latency: a payload pushed at edge N is visible on m_data/m_valid after edge N; minimum 1 cycle, no combinational bypass.
- Ordering: strict FIFO. Once m_valid=1, m_data stays stable until popped or flushed.
- Upstream protocol: s_valid must not drop and s_data must not change while s_valid=1 and s_ready=0. The block does not check this.
- Flush:
  - While flush=1, s_ready=0 and m_valid=0, so no push or pop can occur.
  - At the edge, rd_ptr, wr_ptr and count clear to 0.
  - A flush lasting several cycles keeps the buffer empty.
- Full (count==DEPTH): s_ready=0, and a pop in that cycle does not enable a push in the same cycle.
- Empty (count==0): m_valid=0; a push makes m_valid=1 on the next cycle.
- Counters:
  - stall_cnt increments when m_valid & ~m_ready.
  - bubble_cnt increments when ~m_valid & ~flush.
  - Both saturate at 2^CNT_W-1 and never wrap. Flush does not clear them; only reset does.
- Assertions (simulation only): DEPTH>=1, WIDTH>=1, and count never exceeds DEPTH.

Decomposition:
- Shared package npc_pipe_pkg:
  - function ptr_w(depth) returning max(1,$clog2(depth));
  - function cnt_w(depth) returning $clog2(depth+1);
  - typedef of the perf-counter enable encoding.
- One sub-module sat_counter, parameter W. Ports: clk, rst, inc, value. Saturating increment with asynchronous active-low clear. It is instantiated twice, for stall_cnt and bubble_cnt.
- The stage-specific payload structs are packed by the instantiating top into s_data. This block is payload-agnostic.

Test Plan:
- Reset/idle: DEPTH=2; hold rst=0 for 3 cycles, then release with s_valid=0 for 5 cycles. Required: m_valid=0, count=0 and s_ready=0 during reset, s_ready=1 after; bubble_cnt=5.
- Full-throughput stream: DEPTH=2, m_ready=1; push 0x11, 0x22, 0x33, 0x44 on consecutive cycles. Required: m_data shows the same sequence one cycle later, one per cycle; count stays <=1; stall_cnt=0.
- Backpressure and full: DEPTH=3, m_ready=0; push 0xA0, 0xA1, 0xA2, 0xA3. Required: count reaches 3, s_ready=0, 0xA3 is held upstream, stall_cnt increments each cycle. Then raise m_ready=1. Required: output order 0xA0, 0xA1, 0xA2, 0xA3 with 0xA3 accepted only after a slot frees.
- Flush mid-stream: DEPTH=4 with 3 entries held, m_ready=0; assert flush for 1 cycle with s_valid=1, s_data=0xFF. Required: during flush s_ready=0 and m_valid=0; after it count=0 and 0xFF is not stored. A new push of 0x55 appears as the head one cycle later.
- Wrap-around with non-power-of-2 DEPTH: DEPTH=3; perform 7 pushes and 7 pops with random m_ready (same seed each run). Required: data order is preserved across pointer wrap and count returns to 0.
- DEPTH=1 throughput and counter saturation: DEPTH=1, CNT_W=2, m_ready=1, continuous s_valid. Required: a transfer every 2nd cycle. Then hold m_valid=1, m_ready=0 for 6 cycles. Required: stall_cnt saturates at 3.
